fft8_frame_loader: RTL
======================

// Module: fft8_frame_loader
// PURPOSE
//   Upstream stage of fft8: collects a serial stream of real DW-bit samples into
//   8-sample frames and presents each frame in parallel on x0_o..x7_o, which map
//   one-to-one onto fft8 x0_i..x7_i. Double-buffered (fill bank + output bank):
//   streaming continues while a completed frame is held for the consumer.
// PARAMETERS
//   DW        16   sample width in bits, real and unsigned as carried; matches fft8 input width
//   DROPW      8   width of the saturating dropped-partial-frame counter
// PORTS
//   clk_i          in   1       clock, all state updates on rising edge
//   rst_i          in   1       reset, asynchronous, active-high
//   s_valid_i      in   1       input sample valid
//   s_ready_o      out  1       loader can accept a sample
//   s_data_i       in   DW      input sample
//   s_sof_i        in   1       start of frame: accepted sample becomes index 0
//   frame_valid_o  out  1       x0_o..x7_o hold a complete frame
//   frame_ready_i  in   1       consumer takes the frame
//   x0_o..x7_o     out  DW      parallel frame, xk_o = k-th sample of the frame
//   fill_idx_o     out  3       index the next accepted sample will occupy
//   drop_cnt_o     out  DROPW   partial frames discarded by s_sof_i, saturating
// BEHAVIOUR
//   Reset, rst_i high, async: fill bank, x0_o..x7_o, fill_idx_o, drop_cnt_o = 0;
//     frame_valid_o = 0; fill_full = 0. s_ready_o = 1 once rst_i is low.
//   Input accept: s_valid_i & s_ready_o on a rising edge. s_ready_o = !fill_full
//     (register-driven, with no combinational path from frame_ready_i).
//   Index: the write index is 0 if s_sof_i, else fill_idx_o. Sample goes to fill[index].
//     fill_idx_o <= index+1 mod 8.
//   SOF resync: s_sof_i accepted while fill_idx_o != 0 -> partial frame discarded
//     and drop_cnt_o += 1, saturating at 2^DROPW-1. At fill_idx_o = 0 there is no drop count.
//     s_sof_i without s_valid_i is ignored.
//   Frame completion: the accepted sample lands at index 7. If out_free, the output
//     bank loads fill[0..6] plus s_data_i at that edge and frame_valid_o = 1 next cycle,
//     so latency is 1 clock from the 8th accept.
//     out_free = !frame_valid_o | frame_ready_i.
//     If not out_free -> fill_full <= 1, s_ready_o drops, and the fill bank is held.
//   Transfer: fill_full & out_free on an edge -> output bank <= fill bank,
//     fill_full <= 0, frame_valid_o stays or becomes 1.
//   Output handshake: frame_valid_o & frame_ready_i consumes the frame. frame_valid_o
//     falls the next cycle unless a transfer or completion occurs on the same edge,
//     which gives back-to-back frames with no bubble.
//   x0_o..x7_o are stable while frame_valid_o = 1 and not consumed.
//   frame_ready_i while frame_valid_o = 0 has no effect.
//   Throughput: 1 sample/clock sustained when frame_ready_i is held high.
//   Arithmetic: none on data; samples are passed bit-exact.
//   Reset mid-frame or mid-hold: everything clears immediately. The partial frame is
//     lost and is not counted in drop_cnt_o.
// TESTING
//   1 Stream 0,100,...,700, sof on the first sample, ready = 1 -> one cycle after the 8th
//     accept, frame_valid_o = 1 and x0..x7 = 0,100,...,700. Fed to fft8, this gives X0_r = 2800.
//   2 16 back-to-back samples 1..16, ready = 1 -> two frames {1..8} and {9..16}.
//     s_ready_o stays 1 and frame_valid_o is high for 2 consecutive frame cycles
//     with no bubble.
//   3 frame_ready_i = 0, stream 24 samples -> frame A is held, frame B fills, and
//     s_ready_o = 0 after the 16th accept. Raise ready -> B transfers on that edge,
//     s_ready_o = 1 next cycle, and the third frame completes intact.
//   4 3 samples, then sof with value 42, then 7 more -> drop_cnt_o = 1 and x0_o = 42.
//     Repeat 300 times -> drop_cnt_o saturates at 255.
//   5 Assert rst_i for half a cycle with frame_valid_o = 1 and fill_idx_o = 5 ->
//     all outputs are 0 asynchronously. The next 8 samples form a clean frame.
//   6 Random s_valid_i and frame_ready_i over 10k samples vs scoreboard ->
//     no loss, no duplication, and in-order frames.

Source files
------------

// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel loader in front of fft8: packs DW-bit samples into 8-sample
// frames, double-buffered so the stream keeps flowing while a frame waits for the consumer.
module fft8_frame_loader #(
    parameter int DW    = 16,
    parameter int DROPW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [DW-1:0]    s_data_i,
    input  logic             s_sof_i,
    output logic             frame_valid_o,
    input  logic             frame_ready_i,
    output logic [DW-1:0]    x0_o,
    output logic [DW-1:0]    x1_o,
    output logic [DW-1:0]    x2_o,
    output logic [DW-1:0]    x3_o,
    output logic [DW-1:0]    x4_o,
    output logic [DW-1:0]    x5_o,
    output logic [DW-1:0]    x6_o,
    output logic [DW-1:0]    x7_o,
    output logic [2:0]       fill_idx_o,
    output logic [DROPW-1:0] drop_cnt_o
);

    // Handshakes: a sample moves on a rising edge with s_valid_i & s_ready_o high,
    // a frame moves on a rising edge with frame_valid_o & frame_ready_i high;
    // a valid is never withdrawn by the loader until its transfer has happened.

    logic [DW-1:0]    fill_q [8];
    logic [DW-1:0]    out_q  [8];
    logic             fill_full_q;
    logic             frame_valid_q;
    logic [2:0]       fill_idx_q;
    logic [DROPW-1:0] drop_q;

    logic       accept;
    logic [2:0] wr_idx;
    logic       out_free;
    logic       complete;

    // s_ready_o comes straight from a register, so frame_ready_i never reaches it.
    assign s_ready_o = !fill_full_q && !rst_i;
    assign accept    = s_valid_i && s_ready_o;
    assign wr_idx    = s_sof_i ? 3'd0 : fill_idx_q;
    assign out_free  = !frame_valid_q || frame_ready_i;
    assign complete  = accept && (wr_idx == 3'd7);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 8; k++) begin
                fill_q[k] <= '0;
                out_q[k]  <= '0;
            end
            fill_full_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            fill_idx_q    <= 3'd0;
            drop_q        <= '0;
        end else begin
            if (accept) begin
                fill_q[wr_idx] <= s_data_i;
                fill_idx_q     <= wr_idx + 3'd1;
                if (s_sof_i && (fill_idx_q != 3'd0) && (drop_q != {DROPW{1'b1}}))
                    drop_q <= drop_q + DROPW'(1);
            end

            // Completion and hand-over are mutually exclusive: accept needs !fill_full_q.
            if (complete && out_free) begin
                for (int k = 0; k < 7; k++)
                    out_q[k] <= fill_q[k];
                out_q[7]      <= s_data_i;
                frame_valid_q <= 1'b1;
            end else if (complete) begin
                fill_full_q <= 1'b1;
            end else if (fill_full_q && out_free) begin
                out_q         <= fill_q;
                fill_full_q   <= 1'b0;
                frame_valid_q <= 1'b1;
            end else if (frame_ready_i) begin
                frame_valid_q <= 1'b0;
            end
        end
    end

    assign frame_valid_o = frame_valid_q;
    assign fill_idx_o    = fill_idx_q;
    assign drop_cnt_o    = drop_q;
    assign x0_o = out_q[0];
    assign x1_o = out_q[1];
    assign x2_o = out_q[2];
    assign x3_o = out_q[3];
    assign x4_o = out_q[4];
    assign x5_o = out_q[5];
    assign x6_o = out_q[6];
    assign x7_o = out_q[7];

endmodule
